// File: rtl/fib_seq_gen_if.sv
// rtl/fib_seq_gen_if.sv - control and term-stream bundle for the Fibonacci sequence generator
interface fib_seq_gen_if #(
  parameter int WIDTH  = 32,
  parameter int TERM_W = 8
);
  logic              start;
  logic [TERM_W-1:0] terms;
  logic              mode;
  logic [WIDTH-1:0]  seed0;
  logic [WIDTH-1:0]  seed1;
  logic              out_ready;
  logic              term_valid;
  logic [WIDTH-1:0]  series_value;
  logic [TERM_W-1:0] term_index;
  logic              overflow;
  logic              busy;
  logic              done;

  modport master (
    output start, terms, mode, seed0, seed1, out_ready,
    input  term_valid, series_value, term_index, overflow, busy, done
  );

  modport slave (
    input  start, terms, mode, seed0, seed1, out_ready,
    output term_valid, series_value, term_index, overflow, busy, done
  );
endinterface

// File: rtl/fib_seq_gen.sv
// rtl/fib_seq_gen.sv - Fibonacci/Lucas-type term generator with seeds, back-pressure and sticky overflow
module fib_seq_gen #(
  parameter int WIDTH  = 32,
  parameter int TERM_W = 8
) (
  input  logic         clk,
  input  logic         reset,
  fib_seq_gen_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  cur_q, cur_d;
  logic [WIDTH-1:0]  nxt_q, nxt_d;
  logic              carry_q, carry_d;
  logic [TERM_W-1:0] idx_q, idx_d;
  logic [TERM_W-1:0] last_q, last_d;
  logic              ovf_q, ovf_d;
  logic [WIDTH:0]    sum;

  assign sum = {1'b0, cur_q} + {1'b0, nxt_q};

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    nxt_d   = nxt_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    last_d  = last_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          cur_d   = bus.mode ? bus.seed0 : '0;
          nxt_d   = bus.mode ? bus.seed1 : WIDTH'(1);
          carry_d = 1'b0;
          idx_d   = '0;
          last_d  = bus.terms - TERM_W'(1);
          ovf_d   = 1'b0;
          state_d = (bus.terms == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        // The pair is not advanced past the last term, so overflow only reflects emitted terms.
        if (bus.out_ready) begin
          if (idx_q == last_q) begin
            state_d = S_DONE;
          end else begin
            cur_d   = nxt_q;
            nxt_d   = sum[WIDTH-1:0];
            carry_d = sum[WIDTH];
            idx_d   = idx_q + TERM_W'(1);
            ovf_d   = ovf_q | carry_q;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      nxt_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      last_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      nxt_q   <= nxt_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.term_valid   = (state_q == S_RUN);
  assign bus.series_value = cur_q;
  assign bus.term_index   = idx_q;
  assign bus.overflow     = ovf_q;
  assign bus.busy         = (state_q == S_RUN);
  assign bus.done         = (state_q == S_DONE);
endmodule

// File: tb/tb_fib_seq_gen.sv
// tb/tb_fib_seq_gen.sv - directed self-checking bench for fib_seq_gen
module tb_fib_seq_gen;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fib_seq_gen_if #(.WIDTH(32), .TERM_W(8)) a_if ();
  fib_seq_gen_if #(.WIDTH(8),  .TERM_W(8)) b_if ();

  fib_seq_gen #(.WIDTH(32), .TERM_W(8)) u_a (.clk(clk), .reset(reset), .bus(a_if.slave));
  fib_seq_gen #(.WIDTH(8),  .TERM_W(8)) u_b (.clk(clk), .reset(reset), .bus(b_if.slave));

  int n_checks = 0;
  int n_pass   = 0;
  int hs_a     = 0;
  int unsigned exp_q[$];
  int unsigned ovf_q[$];

  always @(posedge clk) if (a_if.term_valid && a_if.out_ready) hs_a <= hs_a + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_a(input int t, input bit m, input logic [31:0] s0, input logic [31:0] s1);
    a_if.terms = 8'(t);
    a_if.mode  = m;
    a_if.seed0 = s0;
    a_if.seed1 = s1;
    a_if.start = 1'b1;
    tick();
    a_if.start = 1'b0;
  endtask

  // Walks exp_q with out_ready held high; optionally pulses start at index inj.
  task automatic drain_a(input string name, input int inj);
    for (int k = 0; k < exp_q.size(); k++) begin
      check($sformatf("%s_valid[%0d]", name, k), 64'(a_if.term_valid), 64'd1);
      check($sformatf("%s_value[%0d]", name, k), 64'(a_if.series_value), 64'(exp_q[k]));
      check($sformatf("%s_index[%0d]", name, k), 64'(a_if.term_index), 64'(k));
      check($sformatf("%s_busy[%0d]", name, k), 64'(a_if.busy), 64'd1);
      if (k == inj) begin
        a_if.start = 1'b1;
        a_if.terms = 8'd3;
      end
      tick();
      a_if.start = 1'b0;
    end
    check({name, "_done"}, 64'(a_if.done), 64'd1);
    check({name, "_done_valid"}, 64'(a_if.term_valid), 64'd0);
    check({name, "_done_busy"}, 64'(a_if.busy), 64'd0);
    check({name, "_ovf"}, 64'(a_if.overflow), 64'd0);
    tick();
    check({name, "_done_pulse"}, 64'(a_if.done), 64'd0);
  endtask

  initial begin
    reset = 1'b0;
    a_if.start = 0; a_if.terms = 0; a_if.mode = 0; a_if.seed0 = 0; a_if.seed1 = 0; a_if.out_ready = 1;
    b_if.start = 0; b_if.terms = 0; b_if.mode = 0; b_if.seed0 = 0; b_if.seed1 = 0; b_if.out_ready = 1;
    #12;
    check("rst_valid", 64'(a_if.term_valid), 64'd0);
    check("rst_value", 64'(a_if.series_value), 64'd0);
    check("rst_index", 64'(a_if.term_index), 64'd0);
    check("rst_ovf",   64'(a_if.overflow), 64'd0);
    check("rst_busy",  64'(a_if.busy), 64'd0);
    check("rst_done",  64'(a_if.done), 64'd0);
    tick();
    reset = 1'b1;
    tick();

    start_a(5, 0, 0, 0);
    exp_q = '{0, 1, 1, 2, 3};
    drain_a("t5", -1);

    start_a(9, 0, 0, 0);
    exp_q = '{0, 1, 1, 2, 3, 5, 8, 13, 21};
    drain_a("t9", 4);

    start_a(6, 1, 32'd2, 32'd1);
    exp_q = '{2, 1, 3, 4, 7, 11};
    drain_a("seed", -1);
    start_a(3, 0, 32'd2, 32'd1);
    exp_q = '{0, 1, 1};
    drain_a("noseed", -1);

    // Back-pressure while index 2 is presented
    hs_a = 0;
    start_a(6, 0, 0, 0);
    exp_q = '{0, 1, 1, 2, 3, 5};
    tick();
    tick();
    a_if.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("bp_valid[%0d]", c), 64'(a_if.term_valid), 64'd1);
      check($sformatf("bp_value[%0d]", c), 64'(a_if.series_value), 64'd1);
      check($sformatf("bp_index[%0d]", c), 64'(a_if.term_index), 64'd2);
      tick();
    end
    a_if.out_ready = 1'b1;
    for (int k = 2; k < 6; k++) begin
      check($sformatf("bp_value[%0d]", k), 64'(a_if.series_value), 64'(exp_q[k]));
      check($sformatf("bp_index[%0d]", k), 64'(a_if.term_index), 64'(k));
      tick();
    end
    check("bp_done", 64'(a_if.done), 64'd1);
    check("bp_handshakes", 64'(hs_a), 64'd6);
    tick();

    // 8-bit instance: wrap appears at index 14
    exp_q = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 121, 98};
    ovf_q = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    b_if.terms = 8'd16;
    b_if.start = 1'b1;
    tick();
    b_if.start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("w8_value[%0d]", k), 64'(b_if.series_value), 64'(exp_q[k]));
      check($sformatf("w8_index[%0d]", k), 64'(b_if.term_index), 64'(k));
      check($sformatf("w8_ovf[%0d]", k), 64'(b_if.overflow), 64'(ovf_q[k]));
      tick();
    end
    check("w8_done", 64'(b_if.done), 64'd1);
    tick();
    check("w8_ovf_idle", 64'(b_if.overflow), 64'd1);
    b_if.terms = 8'd1;
    b_if.start = 1'b1;
    tick();
    b_if.start = 1'b0;
    check("w8_ovf_clr", 64'(b_if.overflow), 64'd0);
    check("w8_restart_value", 64'(b_if.series_value), 64'd0);
    tick();
    check("w8_restart_done", 64'(b_if.done), 64'd1);
    tick();

    start_a(0, 0, 0, 0);
    check("t0_done", 64'(a_if.done), 64'd1);
    check("t0_valid", 64'(a_if.term_valid), 64'd0);
    tick();
    check("t0_done_pulse", 64'(a_if.done), 64'd0);
    check("t0_valid_after", 64'(a_if.term_valid), 64'd0);
    tick();

    // Reset asserted while index 3 of a 9-term run is presented
    start_a(9, 0, 0, 0);
    for (int k = 0; k < 3; k++) tick();
    check("mr_index_pre", 64'(a_if.term_index), 64'd3);
    check("mr_value_pre", 64'(a_if.series_value), 64'd2);
    reset = 1'b0;
    #1;
    check("mr_valid", 64'(a_if.term_valid), 64'd0);
    check("mr_value", 64'(a_if.series_value), 64'd0);
    check("mr_index", 64'(a_if.term_index), 64'd0);
    check("mr_busy",  64'(a_if.busy), 64'd0);
    check("mr_done",  64'(a_if.done), 64'd0);
    tick();
    tick();
    check("mr_no_done", 64'(a_if.done), 64'd0);
    reset = 1'b1;
    tick();
    start_a(2, 0, 0, 0);
    exp_q = '{0, 1};
    drain_a("mr_rerun", -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
